uart_rx_fifo: RTL and testbench

//  Receive buffer directly downstream of the UART receiver. Captures each
//  one-cycle valid pulse (data byte + BREAK flag) into a circular FIFO.

---
 rtl/uart_rx_fifo_if.sv | 37 +++
 rtl/uart_rx_fifo.sv | 90 +++++++++
 tb/tb_uart_rx_fifo.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// Push/pop/control bundle between the UART receiver, the RX FIFO and the
// register read logic.
interface uart_rx_fifo_if #(
  parameter int PAYLOAD_BITS = 8,
  parameter int DEPTH        = 16
);
  localparam int AW = $clog2(DEPTH);

  logic                    wr_valid;
  logic [PAYLOAD_BITS-1:0] wr_data;
  logic                    wr_break;
  logic                    rd_ready;
  logic                    flush;
  logic                    clr_overrun;
  logic                    rd_valid;
  logic [PAYLOAD_BITS-1:0] rd_data;
  logic                    rd_break;
  logic [AW:0]             level;
  logic                    full;
  logic                    empty;
  logic                    overrun;
  logic                    thresh_hit;

  modport master (
    output wr_valid, wr_data, wr_break,
    output rd_ready, flush, clr_overrun,
    input  rd_valid, rd_data, rd_break,
    input  level, full, empty, overrun, thresh_hit
  );

  modport slave (
    input  wr_valid, wr_data, wr_break,
    input  rd_ready, flush, clr_overrun,
    output rd_valid, rd_data, rd_break,
    output level, full, empty, overrun, thresh_hit
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: circular buffer of {break,data} entries with
// first-word-fall-through pop port, level flags and sticky overrun.
module uart_rx_fifo #(
  parameter int PAYLOAD_BITS = 8,
  parameter int DEPTH        = 16,
  parameter int THRESH       = 8
) (
  input logic           i_clk,
  input logic           i_reset,
  uart_rx_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] THR_LVL  = LW'(THRESH);

  logic [PAYLOAD_BITS:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [LW-1:0]         r_level;
  logic                  r_overrun;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_wr_en;
  logic                  w_drop;
  logic [PAYLOAD_BITS:0] w_head;

  assign w_full  = (r_level == FULL_LVL);
  assign w_empty = (r_level == '0);
  assign w_pop   = !w_empty & bus.rd_ready;
  assign w_push  = bus.wr_valid & (!w_full | w_pop);
  assign w_wr_en = w_push & !bus.flush;
  assign w_drop  = bus.wr_valid & w_full & !w_pop & !bus.flush;
  assign w_head  = r_mem[r_rd_ptr];

  // Entry storage; contents are meaningless until counted by level.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= {bus.wr_break, bus.wr_data};
    end
  end

  // Pointers and occupancy; flush wins over any coincident push/pop.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Sticky overrun; a new drop beats a coincident clear.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (bus.clr_overrun) begin
      r_overrun <= 1'b0;
    end
  end

  assign bus.rd_valid   = !w_empty;
  assign bus.rd_data    = w_head[PAYLOAD_BITS-1:0];
  assign bus.rd_break   = w_head[PAYLOAD_BITS];
  assign bus.level      = r_level;
  assign bus.full       = w_full;
  assign bus.empty      = w_empty;
  assign bus.overrun    = r_overrun;
  assign bus.thresh_hit = (r_level >= THR_LVL);
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: vector table for the simple
// sequences, queue scoreboard for data ordering and level tracking.
module tb_uart_rx_fifo;
  localparam int PB = 8;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;

  logic [PB:0] sb_q [$];
  logic        m_ov;

  uart_rx_fifo_if #(.PAYLOAD_BITS(PB), .DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(.PAYLOAD_BITS(PB), .DEPTH(DEPTH), .THRESH(8)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wv;
    logic [7:0] wd;
    logic       wb;
    logic       rr;
    logic [4:0] e_lvl;
    logic       e_full;
    logic       e_empty;
    logic       e_thr;
    logic       e_ov;
    logic [7:0] e_head;
  } vec_t;

  vec_t vt [$];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // One clock of stimulus; scoreboard checks head on pop, level after edge.
  task automatic step(input logic wv, input logic [7:0] wd, input logic wb,
                      input logic rr, input logic fl, input logic co);
    logic full_m;
    logic pop_m;
    @(negedge clk);
    bus.wr_valid = wv;
    bus.wr_data = wd;
    bus.wr_break = wb;
    bus.rd_ready = rr;
    bus.flush = fl;
    bus.clr_overrun = co;
    #1;
    chk("rd_valid", int'(bus.rd_valid), int'(sb_q.size() > 0));
    full_m = (sb_q.size() == DEPTH);
    pop_m = (sb_q.size() > 0) && rr;
    if (pop_m) begin
      chk("pop_data", int'(bus.rd_data), int'(sb_q[0][7:0]));
      chk("pop_brk", int'(bus.rd_break), int'(sb_q[0][8]));
    end
    if (fl) begin
      sb_q.delete();
    end else begin
      if (pop_m) void'(sb_q.pop_front());
      if (wv && (!full_m || pop_m)) sb_q.push_back({wb, wd});
    end
    if (wv && full_m && !pop_m && !fl) m_ov = 1'b1;
    else if (co) m_ov = 1'b0;
    @(posedge clk);
    #1;
    chk("level", int'(bus.level), sb_q.size());
    chk("overrun", int'(bus.overrun), int'(m_ov));
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    bus.flush = 1'b0;
    bus.clr_overrun = 1'b0;
  endtask

  function automatic vec_t mk(logic wv, logic [7:0] wd, logic rr,
                              int lvl, logic thr, logic [7:0] hd);
    vec_t v;
    v.wv = wv;
    v.wd = wd;
    v.wb = 1'b0;
    v.rr = rr;
    v.e_lvl = 5'(lvl);
    v.e_full = (lvl == DEPTH);
    v.e_empty = (lvl == 0);
    v.e_thr = thr;
    v.e_ov = 1'b0;
    v.e_head = hd;
    return v;
  endfunction

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_data = '0;
    bus.wr_break = 1'b0;
    bus.rd_ready = 1'b0;
    bus.flush = 1'b0;
    bus.clr_overrun = 1'b0;
    m_ov = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_level", int'(bus.level), 0);
    chk("rst_empty", int'(bus.empty), 1);
    chk("rst_full", int'(bus.full), 0);
    chk("rst_thr", int'(bus.thresh_hit), 0);
    chk("rst_valid", int'(bus.rd_valid), 0);
    chk("rst_ov", int'(bus.overrun), 0);
    @(negedge clk);
    reset = 1'b0;

    // Basic push/pop, then threshold crossing.
    vt.push_back(mk(1, 8'hA5, 0, 1, 0, 8'hA5));
    vt.push_back(mk(1, 8'h3C, 0, 2, 0, 8'hA5));
    vt.push_back(mk(0, 8'h00, 0, 2, 0, 8'hA5));
    vt.push_back(mk(0, 8'h00, 1, 1, 0, 8'h3C));
    vt.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00));
    for (int i = 0; i < 7; i++)
      vt.push_back(mk(1, 8'(8'h10 + i), 0, i + 1, 0, 8'h10));
    vt.push_back(mk(1, 8'h17, 0, 8, 1, 8'h10));
    vt.push_back(mk(0, 8'h00, 1, 7, 0, 8'h11));
    for (int i = 0; i < 7; i++)
      vt.push_back(mk(0, 8'h00, 1, 6 - i, 0, 8'(8'h12 + i)));

    foreach (vt[i]) begin
      step(vt[i].wv, vt[i].wd, vt[i].wb, vt[i].rr, 1'b0, 1'b0);
      chk($sformatf("v%0d_lvl", i), int'(bus.level), int'(vt[i].e_lvl));
      chk($sformatf("v%0d_full", i), int'(bus.full), int'(vt[i].e_full));
      chk($sformatf("v%0d_empty", i), int'(bus.empty), int'(vt[i].e_empty));
      chk($sformatf("v%0d_thr", i), int'(bus.thresh_hit), int'(vt[i].e_thr));
      chk($sformatf("v%0d_ov", i), int'(bus.overrun), int'(vt[i].e_ov));
      if (vt[i].e_lvl != 0)
        chk($sformatf("v%0d_head", i), int'(bus.rd_data), int'(vt[i].e_head));
    end

    // Fill to full, overrun, clear, then push+pop while full.
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0, 0, 0);
    chk("fill_full", int'(bus.full), 1);
    chk("fill_ov", int'(bus.overrun), 0);
    step(1, 8'hFF, 0, 0, 0, 0);
    chk("ovr_set", int'(bus.overrun), 1);
    chk("ovr_lvl", int'(bus.level), 16);
    step(0, 8'h00, 0, 0, 0, 1);
    chk("ovr_clr", int'(bus.overrun), 0);
    step(1, 8'h77, 0, 1, 0, 0);
    chk("pp_full_lvl", int'(bus.level), 16);
    chk("pp_full_ov", int'(bus.overrun), 0);
    for (int i = 0; i < 15; i++) step(0, 8'h00, 0, 1, 0, 0);
    chk("pp_last", int'(bus.rd_data), 8'h77);
    step(0, 8'h00, 0, 1, 0, 0);
    chk("drain_empty", int'(bus.empty), 1);

    // Interleaved traffic, pointers wrap repeatedly.
    for (int i = 0; i < 40; i++)
      step(1, 8'(8'h40 + i), 1'(i % 5 == 0), 1'((i % 3) != 0), 0, 0);
    while (sb_q.size() > 0) step(0, 8'h00, 0, 1, 0, 0);
    chk("wrap_empty", int'(bus.empty), 1);

    // Overrun, drain to 5, flush with push, clear, BREAK, async reset.
    for (int i = 0; i < 17; i++) step(1, 8'(8'h80 + i), 0, 0, 0, 0);
    for (int i = 0; i < 11; i++) step(0, 8'h00, 0, 1, 0, 0);
    chk("f_lvl5", int'(bus.level), 5);
    chk("f_ov1", int'(bus.overrun), 1);
    step(1, 8'h55, 0, 1, 1, 0);
    chk("flush_lvl", int'(bus.level), 0);
    chk("flush_ov", int'(bus.overrun), 1);
    step(0, 8'h00, 0, 0, 0, 1);
    chk("clr_ov", int'(bus.overrun), 0);
    step(1, 8'h00, 1, 0, 0, 0);
    chk("brk_flag", int'(bus.rd_break), 1);
    chk("brk_data", int'(bus.rd_data), 0);
    step(1, 8'h21, 0, 0, 0, 0);
    step(1, 8'h22, 0, 0, 0, 0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_lvl", int'(bus.level), 0);
    chk("arst_empty", int'(bus.empty), 1);
    sb_q.delete();
    m_ov = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    step(1, 8'h99, 0, 0, 0, 0);
    chk("post_rst_head", int'(bus.rd_data), 8'h99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
